// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: issue-side controller for one dsp48a1 slice used as a
// multiply-accumulator. It streams operand pairs into A/B and sequences the
// clock enables and OPMODE to follow the slice pipeline. It captures the
// accumulator from PM and returns it over a valid/ready port.
// Slice setup assumed: A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0,
// B_INPUT="DIRECT", RSTTYPE="SYNC", CARRYIN tied 0.
// Optional feature: define DSP_MAC_ABORT_EN to add the ABORT port.
module dsp_mac_sequencer #(
  parameter int          LEN_W    = 8,
  parameter logic [7:0]  OPM_LOAD = 8'h01,
  parameter logic [7:0]  OPM_ACC  = 8'h09
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  output logic             BUSY,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [17:0]      S_A,
  input  logic [17:0]      S_B,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [47:0]      RES_DATA,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_CEA,
  output logic             DSP_CEB,
  output logic             DSP_CEM,
  output logic             DSP_CEP,
  output logic             DSP_CEOPMODE,
  output logic             DSP_RST,
`ifdef DSP_MAC_ABORT_EN
  input  logic             ABORT,
`endif
  input  logic [47:0]      DSP_PM
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   cnt_reg;
  logic [LEN_W-1:0]   cnt_inc;
  logic [1:0]         drain_cnt_reg;
  logic [47:0]        res_data_reg;
  logic               abort_pulse_reg;
  logic               tag_valid_reg [0:1];
  logic               tag_first_reg;
  logic               accept;
  logic               last_sample;
  logic               abort_req;

`ifdef DSP_MAC_ABORT_EN
  assign abort_req = ABORT && (state_reg != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign S_READY     = (state_reg == RUN);
  assign BUSY        = (state_reg != IDLE);
  assign RES_VALID   = (state_reg == DONE);
  assign RES_DATA    = res_data_reg;
  assign accept      = S_VALID && S_READY;
  assign cnt_inc     = cnt_reg + 1'b1;
  assign last_sample = (cnt_inc == len_reg);

  // Operands go straight to the slice; its A1/B1 registers do the capture.
  assign DSP_A        = S_A;
  assign DSP_B        = S_B;
  assign DSP_CEA      = accept;
  assign DSP_CEB      = accept;
  assign DSP_CEM      = tag_valid_reg[0];
  assign DSP_CEP      = tag_valid_reg[1];
  assign DSP_CEOPMODE = BUSY;
  // The first product of a job restarts P (Z=0); later ones accumulate.
  assign DSP_OPMODE   = (tag_valid_reg[0] && tag_first_reg) ? OPM_LOAD : OPM_ACC;
  assign DSP_RST      = RST || abort_pulse_reg;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (START) state_next = (LEN == '0) ? DONE : RUN;
      RUN:   if (accept && last_sample) state_next = DRAIN;
      DRAIN: if (drain_cnt_reg == 2'd2) state_next = DONE;
      DONE:  if (RES_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_req) state_next = IDLE;
  end

  // Job length, sample count, drain timer and result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      len_reg         <= '0;
      cnt_reg         <= '0;
      drain_cnt_reg   <= 2'd0;
      res_data_reg    <= 48'd0;
      abort_pulse_reg <= 1'b0;
    end else begin
      abort_pulse_reg <= abort_req;
      if (!abort_req) begin
        case (state_reg)
          IDLE: begin
            if (START) begin
              len_reg       <= LEN;
              cnt_reg       <= '0;
              drain_cnt_reg <= 2'd0;
              if (LEN == '0) res_data_reg <= 48'd0;
            end
          end
          RUN: begin
            drain_cnt_reg <= 2'd0;
            if (accept) cnt_reg <= cnt_inc;
          end
          DRAIN: begin
            drain_cnt_reg <= drain_cnt_reg + 2'd1;
            // P holds the final sum in the third drain cycle.
            if (drain_cnt_reg == 2'd2) res_data_reg <= DSP_PM;
          end
          default: ;
        endcase
      end
    end
  end

  // First-sample flag travels with stage 0 only; stage 1 needs just valid.
  always_ff @(posedge CLK) begin
    if (RST || abort_req) tag_first_reg <= 1'b0;
    else                  tag_first_reg <= accept && (cnt_reg == '0);
  end

  // Two-stage valid tag pipeline mirroring the slice's M and P registers.
  for (genvar gi = 0; gi < 2; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      always_ff @(posedge CLK) begin
        if (RST || abort_req) tag_valid_reg[gi] <= 1'b0;
        else                  tag_valid_reg[gi] <= accept;
      end
    end else begin : g_tail
      always_ff @(posedge CLK) begin
        if (RST || abort_req) tag_valid_reg[gi] <= 1'b0;
        else                  tag_valid_reg[gi] <= tag_valid_reg[gi-1];
      end
    end
  end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Issue-side controller for one `dsp48a1` slice configured as a multiply-accumulator. It accepts a dot-product job of length `LEN` and streams 18-bit operand pairs into the slice's A/B ports. It drives the clock enables and OPMODE in step with the slice pipeline, then captures the 48-bit accumulator from `PM` and returns it over a valid/ready result port. It is the initiator for the slice's datapath.

## Interface
- `LEN_W`, 8, width of job length.
- `OPM_LOAD`, 8'h01, OPMODE for the first product: X=M, Z=0.
- `OPM_ACC`, 8'h09, OPMODE for later products: X=M, Z=P.
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: job request, sampled in IDLE only.
- `LEN` in `LEN_W`: number of operand pairs, latched on START.
- `BUSY` out 1: high in every state except IDLE.
- `S_VALID` in 1 / `S_READY` out 1: operand handshake.
- `S_A`, `S_B` in 18: signed operands.
- `RES_VALID` out 1 / `RES_READY` in 1: result handshake.
- `RES_DATA` out 48: accumulated result.
- `DSP_A`, `DSP_B` out 18: drive the slice's A and B ports.
- `DSP_OPMODE` out 8: drives the slice's OPMODE port.
- `DSP_CEA`, `DSP_CEB`, `DSP_CEM`, `DSP_CEP`, `DSP_CEOPMODE` out 1: drive the slice's clock enables.
- `DSP_RST` out 1: drives every slice RST* input.
- `DSP_PM` in 48: slice PM output.
- `ABORT` in 1: present only with `DSP_MAC_ABORT_EN`.

## Operation
- Required slice configuration:
  - A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1
  - B_INPUT="DIRECT", RSTTYPE="SYNC"
  - CARRYIN tied 0
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On START with LEN≠0: latch LEN, clear sample count, go to RUN.
  - On START with LEN=0: load `RES_DATA`=0 and go to DONE. No slice activity.
- RUN:
  - `S_READY`=1.
  - Accept = `S_VALID`&`S_READY`.
  - Count increments on each accept.
  - The accept of sample LEN moves the FSM to DRAIN on the same edge.
- DRAIN:
  - Lasts exactly 3 cycles.
  - On the last DRAIN edge, `RES_DATA`<=`DSP_PM`, then go to DONE.
- DONE:
  - `RES_VALID`=1 with `RES_DATA` held stable.
  - On `RES_VALID`&`RES_READY`, go to IDLE.
- START outside IDLE is ignored.
- Slice drive:
  - `DSP_A`=`S_A` and `DSP_B`=`S_B` combinationally.
  - `DSP_CEA`=`DSP_CEB`=accept.
- Tag pipeline:
  - 2-stage shift register of {valid, first} per accepted sample; first=1 for sample 1 of a job.
  - `DSP_CEM`=tag1.valid.
  - `DSP_CEP`=tag2.valid.
  - `DSP_CEOPMODE`=`BUSY`.
  - `DSP_OPMODE`=`OPM_LOAD` when tag1.valid&tag1.first, otherwise `OPM_ACC`.
- Bubbles (no accept) propagate as CE=0, so P holds.
- Arithmetic:
  - Signed 18×18 products are sign-extended to 48 bits.
  - Accumulation wraps modulo 2^48. No saturation, no overflow flag.
- `DSP_RST`=`RST`, plus the abort pulse below.

## Timing
- Reset values:
  - State IDLE.
  - `BUSY`, `S_READY`, `RES_VALID`, all `DSP_CE*` = 0.
  - `RES_DATA`=0.
  - `DSP_OPMODE`=`OPM_ACC`.
  - Tags cleared.
  - `DSP_RST`=1 while `RST`=1.
- For a sample accepted in cycle t:
  - OPMODE is presented in t+1.
  - CEP is high in t+2.
  - P is valid in t+3.
- Result latency: last accept in cycle t gives `RES_VALID` high from t+4.
- Throughput: 1 pair per cycle. LEN=N with no bubbles completes in N+4 cycles from the first accept.
- LEN=0: `RES_VALID` is high in the cycle after START.
- RST mid-job: next cycle shows reset values regardless of state. A partial result is discarded.

## Configuration
- Macro `DSP_MAC_ABORT_EN`.
- Defined:
  - The `ABORT` port exists.
  - `ABORT`=1 in a non-IDLE state makes the next cycle IDLE with `RES_VALID`=0, `S_READY`=0 and tags cleared.
  - `DSP_RST` is 1 for exactly that one cycle.
  - `ABORT` in IDLE has no effect.
  - `ABORT` has priority over START and over the result handshake.
- Undefined: no `ABORT` port. All other behaviour is identical.

## Test plan
- LEN=4, A={1,2,3,4}, B={5,6,7,8}, back-to-back -> `RES_DATA`=70, `RES_VALID` rises 4 cycles after the last accept.
- LEN=2, A={-3,131071}, B={7,-2} -> `RES_DATA`=48'hFFFF_FFFB_FFED (−262163).
- LEN=3, A=B-pairs {2,3}×3 with `S_VALID` low for 2 cycles between samples -> `RES_DATA`=18, `DSP_CEP` pulses exactly 3 times.
- Two jobs: LEN=1 10×10, then LEN=1 1×1, with `RES_READY` low for 5 cycles on job 1 -> 100 held stable, START during DONE ignored, job 2 = 1 (no carry-over).
- LEN=0 -> `RES_VALID` the next cycle with 0, `DSP_CEA` never asserted.
- `RST` pulse during RUN after 2 of 4 samples -> all outputs at reset values next cycle, `DSP_RST`=1. A fresh LEN=1 job of 2×2 then returns 4. With `DSP_MAC_ABORT_EN`, the same case using `ABORT` instead of `RST` gives the same result.
